// File: rtl/muldiv_sequencer_if.sv
// Operation handshake and result bus for muldiv_sequencer.
// The master drives the request; the slave (the sequencer) returns status and results.
interface muldiv_sequencer_if;
  logic        start;
  logic [4:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        divz;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input busy, done, divz, HI, LO);
  modport slave  (input start, op, A, B, output busy, done, divz, HI, LO);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 32x32 signed multiplier (radix-2 Booth) with optional restoring divider.
// Define MULDIV_DIV_EN to compile in the divider, DIV_RUN state and divz.
//
// state   | meaning
// IDLE    | waiting for start with a supported op
// MUL_RUN | one Booth step per cycle, 32 steps
// DIV_RUN | one restoring step per cycle on magnitudes, 32 steps (1 cycle if B==0)
// DONE    | done pulse, HI/LO freshly loaded; returns to IDLE
module muldiv_sequencer (
  input  logic                 clock,
  input  logic                 clear,
  muldiv_sequencer_if.slave    bus
);

  localparam logic [4:0] OP_MUL = 5'b01111;
`ifdef MULDIV_DIV_EN
  localparam logic [4:0] OP_DIV = 5'b10000;
`endif

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;

  // Booth working register {acc, mplr, q1}
  logic [31:0] mcand;
  logic [31:0] acc;
  logic [31:0] mplr;
  logic        q1;

  logic [32:0] booth_sum;
  logic [31:0] acc_nx;
  logic [31:0] mplr_nx;

  // Sum is formed in 33 bits so the shifted-in sign is right even for mcand = -2^31.
  always_comb begin
    booth_sum = {acc[31], acc};
    case ({mplr[0], q1})
      2'b01:   booth_sum = {acc[31], acc} + {mcand[31], mcand};
      2'b10:   booth_sum = {acc[31], acc} - {mcand[31], mcand};
      default: booth_sum = {acc[31], acc};
    endcase
    acc_nx  = booth_sum[32:1];
    mplr_nx = {booth_sum[0], mplr[31:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic        dz;

  logic [32:0] trial;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] quo_sgn;
  logic [31:0] rem_sgn;
  logic [31:0] a_raw;

  always_comb begin
    trial = {rem, quo[31]} - {1'b0, dvs};
    if (trial[32]) begin
      rem_nx = {rem[30:0], quo[31]};
      quo_nx = {quo[30:0], 1'b0};
    end else begin
      rem_nx = trial[31:0];
      quo_nx = {quo[30:0], 1'b1};
    end
    quo_sgn = neg_q ? -quo_nx : quo_nx;
    rem_sgn = neg_r ? -rem_nx : rem_nx;
    // quo still holds |A| before any step; re-signing restores the original dividend
    a_raw   = neg_r ? -quo : quo;
  end
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.divz <= 1'b0;
      bus.HI   <= 32'd0;
      bus.LO   <= 32'd0;
      mcand    <= 32'd0;
      acc      <= 32'd0;
      mplr     <= 32'd0;
      q1       <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      bus.divz <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.op == OP_MUL) begin
            mcand    <= bus.A;
            acc      <= 32'd0;
            mplr     <= bus.B;
            q1       <= 1'b0;
            cnt      <= 6'd0;
            bus.busy <= 1'b1;
            state    <= MUL_RUN;
          end
`ifdef MULDIV_DIV_EN
          else if (bus.start && bus.op == OP_DIV) begin
            quo      <= bus.A[31] ? -bus.A : bus.A;
            rem      <= 32'd0;
            dvs      <= bus.B[31] ? -bus.B : bus.B;
            neg_q    <= bus.A[31] ^ bus.B[31];
            neg_r    <= bus.A[31];
            dz       <= (bus.B == 32'd0);
            cnt      <= 6'd0;
            bus.busy <= 1'b1;
            state    <= DIV_RUN;
          end
`endif
        end
        MUL_RUN: begin
          acc  <= acc_nx;
          mplr <= mplr_nx;
          q1   <= mplr[0];
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            bus.HI   <= acc_nx;
            bus.LO   <= mplr_nx;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DIV_RUN: begin
`ifdef MULDIV_DIV_EN
          if (dz) begin
            bus.HI   <= a_raw;
            bus.LO   <= 32'hFFFF_FFFF;
            bus.divz <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              bus.HI   <= rem_sgn;
              bus.LO   <= quo_sgn;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
`else
          bus.busy <= 1'b0;
          state    <= IDLE;
`endif
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 clock  input  1  single system clock; all state updates on its rising edge.
REQ-002 clear  input  1  reset, synchronous and active-high, sampled on rising edge of clock.
REQ-003 start  input  1  request to begin an operation, qualified by op.
REQ-004 op  input  5  operation code: 5'b01111 MUL, 5'b10000 DIV; all other codes unsupported.
REQ-005 A  input  32  signed multiplicand or dividend, sampled on the accept edge only.
REQ-006 B  input  32  signed multiplier or divisor, sampled on the accept edge only.
REQ-007 busy  output  1  high while an operation is iterating.
REQ-008 done  output  1  one-cycle pulse: HI/LO hold a fresh result.
REQ-009 divz  output  1  high with done when the completed DIV had B == 0.
REQ-010 HI  output  32  MUL: product[63:32]; DIV: remainder.
REQ-011 LO  output  32  MUL: product[31:0]; DIV: quotient.

Function
REQ-012 States SHALL be IDLE, MUL_RUN, DIV_RUN, DONE, with a 6-bit iteration counter.
REQ-013 Accept: in IDLE with start=1 and a supported op at edge N, capture A, B, op, set counter=0, and go to MUL_RUN or DIV_RUN.
REQ-014 start SHALL be ignored in MUL_RUN, DIV_RUN and DONE, and with an unsupported op; state stays unchanged.
REQ-015 MUL_RUN SHALL perform one radix-2 Booth step per cycle on a 65-bit {acc, multiplier, q-1} register, 32 steps at edges N+1..N+32.
REQ-016 DIV_RUN SHALL perform one restoring step per cycle on operand magnitudes, 32 steps at edges N+1..N+32, then apply signs.
REQ-017 At edge N+32 the FSM SHALL enter DONE, load HI/LO, and assert done for exactly one cycle. Edge N+33 returns it to IDLE.
REQ-018 busy SHALL be 1 after edge N through the last RUN cycle, and 0 in IDLE and DONE.
REQ-019 MUL result SHALL be the exact signed 64-bit product; 0x80000000*0x80000000 = HI 0x40000000, LO 0.
REQ-020 DIV SHALL truncate toward zero. The remainder SHALL take the dividend's sign.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (wrap, no flag).
REQ-022 DIV with B==0 SHALL skip iteration: DIV_RUN goes to DONE at edge N+1 with HI=A, LO=0xFFFFFFFF, divz=1.
REQ-023 HI/LO SHALL hold their last result until the next DONE load or clear. They SHALL not change during RUN.
REQ-024 divz SHALL be 0 whenever done is 0.

Reset
REQ-025 clear=1 at any edge, including mid-operation, SHALL force IDLE, counter=0, busy=0, done=0, divz=0, HI=0, LO=0.
REQ-026 clear SHALL take priority over start on the same edge. An aborted operation SHALL produce no done pulse.

Configuration
REQ-027 Macro MULDIV_DIV_EN defined: DIV datapath, DIV_RUN state and divz SHALL be compiled in, as specified above.
REQ-028 Macro MULDIV_DIV_EN undefined: op 5'b10000 SHALL be unsupported (start ignored), divz SHALL be tied 0, and no divider logic SHALL be synthesized.

Verification
REQ-029 MUL A=7, B=0xFFFFFFFD, start at edge N -> done high after edge N+32, HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy high for 32 cycles.
REQ-030 DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, divz=0.
REQ-031 DIV A=5, B=0 -> done after edge N+1, divz=1, HI=5, LO=0xFFFFFFFF.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; MUL 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
REQ-033 MUL started, clear asserted when counter=10 -> next cycle busy=0, HI=LO=0, and no done within 40 cycles.
REQ-034 Second start (MUL 3*3) asserted while busy, and start with op=5'b00011 in IDLE -> both ignored; first result is unchanged and there is no extra done.
